ctrl_unit_fsm_p: RTL and testbench

Parametrised multi-cycle control unit for the enhanced processor. It fetches instructions through R(NUM_REGS-1) (the PC), decodes them and sequences the integer datapath and the FPU. Register count, memory latency and FPU latency are generalised; it adds an FPU done-handshake with timeout, SUBF, HALT and illegal-opcode handling. It sits between instruction memory (din) and the register file / ALU / FPU enables.

---
 rtl/ctrl_pkg.sv | 57 +++++
 rtl/ctrl_unit_fsm_p_if.sv | 35 +++
 rtl/decoder_n.sv | 13 +
 rtl/ctrl_unit_fsm_p.sv | 250 +++++++++++++++++++++++++
 tb/tb_ctrl_unit_fsm_p.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and instruction field helpers for ctrl_unit_fsm_p
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET  = 5'd0,
        S_LDADDR = 5'd1,
        S_MWAIT  = 5'd2,
        S_FETCH  = 5'd3,
        S_DECODE = 5'd4,
        S_MV     = 5'd5,
        S_NOP    = 5'd6,
        S_MVI_A  = 5'd7,
        S_MVI_W  = 5'd8,
        S_MVI_D  = 5'd9,
        S_AL1    = 5'd10,
        S_AL2    = 5'd11,
        S_AL3    = 5'd12,
        S_LD_A   = 5'd13,
        S_LD_W   = 5'd14,
        S_LD_D   = 5'd15,
        S_ST1    = 5'd16,
        S_ST2    = 5'd17,
        S_ST3    = 5'd18,
        S_F1     = 5'd19,
        S_F2     = 5'd20,
        S_FW     = 5'd21,
        S_F3     = 5'd22,
        S_FERR   = 5'd23,
        S_HALT   = 5'd24,
        S_ILL    = 5'd25
    } state_t;

    typedef enum logic [3:0] {
        OP_MV   = 4'd0,
        OP_MVI  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_LD   = 4'd4,
        OP_ST   = 4'd5,
        OP_MVNZ = 4'd6,
        OP_ADDF = 4'd7,
        OP_SUBF = 4'd8,
        OP_HALT = 4'd9
    } opcode_t;

    localparam int OPC_W = 4;

    // Instruction layout: opcode above X, X above Y, each register field SEL_W bits.
    function automatic int opc_lsb(input int sel_w);
        return 2 * sel_w;
    endfunction

    function automatic int x_lsb(input int sel_w);
        return sel_w;
    endfunction

endpackage

// File: rtl/ctrl_unit_fsm_p_if.sv
// rtl/ctrl_unit_fsm_p_if.sv - memory, datapath and FPU control bundle around the control unit
interface ctrl_unit_fsm_p_if #(
    parameter int NUM_REGS = 8,
    parameter int IW       = 4 + 2 * $clog2(NUM_REGS)
);
    logic [IW-1:0]       din;
    logic                g_nz;
    logic                fpu_done;
    logic [IW-1:0]       ir;
    logic [4:0]          state;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic                din_out, a_in, g_in, g_out, add_sub;
    logic                af_in, gf_in, gf_out, fpu_sub, fpu_start;
    logic                addr_in, dout_in, w_d, incr_pc;
    logic                ir_in, done, halted, illegal, fpu_err;

    modport master (
        input  din, g_nz, fpu_done,
        output ir, state, reg_in, reg_out,
        output din_out, a_in, g_in, g_out, add_sub,
        output af_in, gf_in, gf_out, fpu_sub, fpu_start,
        output addr_in, dout_in, w_d, incr_pc,
        output ir_in, done, halted, illegal, fpu_err
    );

    modport slave (
        output din, g_nz, fpu_done,
        input  ir, state, reg_in, reg_out,
        input  din_out, a_in, g_in, g_out, add_sub,
        input  af_in, gf_in, gf_out, fpu_sub, fpu_start,
        input  addr_in, dout_in, w_d, incr_pc,
        input  ir_in, done, halted, illegal, fpu_err
    );
endinterface

// File: rtl/decoder_n.sv
// rtl/decoder_n.sv - binary register select to one-hot enable vector
module decoder_n #(
    parameter int SEL_W = 3,
    parameter int N     = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     onehot
);
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end
endmodule

// File: rtl/ctrl_unit_fsm_p.sv
// rtl/ctrl_unit_fsm_p.sv - multi-cycle fetch/decode/execute sequencer for integer datapath and FPU
module ctrl_unit_fsm_p
    import ctrl_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int IW       = 4 + 2 * SEL_W,
    parameter int MEM_LAT  = 2,
    parameter int FPU_TMO  = 15
) (
    input logic           clk,
    input logic           rst,
    ctrl_unit_fsm_p_if.master bus
);
    localparam int OPC_LSB   = opc_lsb(SEL_W);
    localparam int X_LSB     = x_lsb(SEL_W);
    localparam int CNT_TOP   = (MEM_LAT > FPU_TMO) ? MEM_LAT : FPU_TMO;
    localparam int CNT_W     = $clog2(CNT_TOP + 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] FPU_LAST = CNT_W'(FPU_TMO - 1);
    localparam logic [NUM_REGS-1:0] PC_OH = {1'b1, {(NUM_REGS-1){1'b0}}};

    state_t              state_q, state_d;
    logic [IW-1:0]       ir_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [OPC_W-1:0]    opc;
    logic [SEL_W-1:0]    x_sel, y_sel;
    logic [NUM_REGS-1:0] x_oh, y_oh;

    logic x_wr, x_rd, y_rd, pc_rd;
    logic din_out, a_in, g_in, g_out, add_sub;
    logic af_in, gf_in, gf_out, fpu_sub, fpu_start;
    logic addr_in, dout_in, w_d, incr_pc;
    logic ir_in, done, halted, illegal, fpu_err;

    assign opc   = ir_q[OPC_LSB +: OPC_W];
    assign x_sel = ir_q[X_LSB +: SEL_W];
    assign y_sel = ir_q[0 +: SEL_W];

    decoder_n #(.SEL_W(SEL_W), .N(NUM_REGS)) u_dec_x (.sel(x_sel), .onehot(x_oh));
    decoder_n #(.SEL_W(SEL_W), .N(NUM_REGS)) u_dec_y (.sel(y_sel), .onehot(y_oh));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                ir_q <= bus.din;
            end
        end
    end

    // Wait counter restarts at zero on every state change and saturates while a state is held.
    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_wr      = 1'b0;
        x_rd      = 1'b0;
        y_rd      = 1'b0;
        pc_rd     = 1'b0;
        din_out   = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        g_out     = 1'b0;
        add_sub   = 1'b0;
        af_in     = 1'b0;
        gf_in     = 1'b0;
        gf_out    = 1'b0;
        fpu_sub   = 1'b0;
        fpu_start = 1'b0;
        addr_in   = 1'b0;
        dout_in   = 1'b0;
        w_d       = 1'b0;
        incr_pc   = 1'b0;
        ir_in     = 1'b0;
        done      = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        fpu_err   = 1'b0;

        case (state_q)
            S_RESET: state_d = S_LDADDR;
            S_LDADDR: begin
                pc_rd   = 1'b1;
                addr_in = 1'b1;
                state_d = S_MWAIT;
            end
            S_MWAIT: begin
                incr_pc = (cnt_q == '0);
                if (cnt_q == MEM_LAST) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_in   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opc)
                    OP_MV:   state_d = S_MV;
                    OP_MVI:  state_d = S_MVI_A;
                    OP_ADD,
                    OP_SUB:  state_d = S_AL1;
                    OP_LD:   state_d = S_LD_A;
                    OP_ST:   state_d = S_ST1;
                    // g_nz is sampled here so the move cycle stays a pure function of state.
                    OP_MVNZ: state_d = bus.g_nz ? S_MV : S_NOP;
                    OP_ADDF,
                    OP_SUBF: state_d = S_F1;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_ILL;
                endcase
            end
            S_MV: begin
                y_rd    = 1'b1;
                x_wr    = 1'b1;
                done    = 1'b1;
                state_d = S_LDADDR;
            end
            S_NOP: begin
                done    = 1'b1;
                state_d = S_LDADDR;
            end
            S_MVI_A: begin
                pc_rd   = 1'b1;
                addr_in = 1'b1;
                state_d = S_MVI_W;
            end
            S_MVI_W: if (cnt_q == MEM_LAST) state_d = S_MVI_D;
            S_MVI_D: begin
                din_out = 1'b1;
                x_wr    = 1'b1;
                incr_pc = 1'b1;
                done    = 1'b1;
                state_d = S_LDADDR;
            end
            S_AL1: begin
                x_rd    = 1'b1;
                a_in    = 1'b1;
                state_d = S_AL2;
            end
            S_AL2: begin
                y_rd    = 1'b1;
                g_in    = 1'b1;
                add_sub = opc[0];
                state_d = S_AL3;
            end
            S_AL3: begin
                g_out   = 1'b1;
                x_wr    = 1'b1;
                done    = 1'b1;
                state_d = S_LDADDR;
            end
            S_LD_A: begin
                y_rd    = 1'b1;
                addr_in = 1'b1;
                state_d = S_LD_W;
            end
            S_LD_W: if (cnt_q == MEM_LAST) state_d = S_LD_D;
            S_LD_D: begin
                din_out = 1'b1;
                x_wr    = 1'b1;
                done    = 1'b1;
                state_d = S_LDADDR;
            end
            S_ST1: begin
                x_rd    = 1'b1;
                dout_in = 1'b1;
                state_d = S_ST2;
            end
            S_ST2: begin
                y_rd    = 1'b1;
                addr_in = 1'b1;
                state_d = S_ST3;
            end
            S_ST3: begin
                w_d     = 1'b1;
                done    = 1'b1;
                state_d = S_LDADDR;
            end
            S_F1: begin
                x_rd    = 1'b1;
                af_in   = 1'b1;
                state_d = S_F2;
            end
            S_F2: begin
                y_rd      = 1'b1;
                gf_in     = 1'b1;
                fpu_start = 1'b1;
                fpu_sub   = (opc == OP_SUBF);
                state_d   = bus.fpu_done ? S_F3 : S_FW;
            end
            S_FW: begin
                fpu_sub = (opc == OP_SUBF);
                if (bus.fpu_done)           state_d = S_F3;
                else if (cnt_q == FPU_LAST) state_d = S_FERR;
            end
            S_F3: begin
                gf_out  = 1'b1;
                x_wr    = 1'b1;
                done    = 1'b1;
                state_d = S_LDADDR;
            end
            S_FERR: begin
                fpu_err = 1'b1;
                done    = 1'b1;
                state_d = S_LDADDR;
            end
            S_HALT: halted = 1'b1;
            S_ILL: begin
                illegal = 1'b1;
                done    = 1'b1;
                state_d = S_LDADDR;
            end
            default: state_d = S_RESET;
        endcase
    end

    assign bus.ir        = ir_q;
    assign bus.state     = state_q;
    assign bus.reg_in    = x_wr ? x_oh : '0;
    assign bus.reg_out   = (x_rd ? x_oh : '0) | (y_rd ? y_oh : '0) | (pc_rd ? PC_OH : '0);
    assign bus.din_out   = din_out;
    assign bus.a_in      = a_in;
    assign bus.g_in      = g_in;
    assign bus.g_out     = g_out;
    assign bus.add_sub   = add_sub;
    assign bus.af_in     = af_in;
    assign bus.gf_in     = gf_in;
    assign bus.gf_out    = gf_out;
    assign bus.fpu_sub   = fpu_sub;
    assign bus.fpu_start = fpu_start;
    assign bus.addr_in   = addr_in;
    assign bus.dout_in   = dout_in;
    assign bus.w_d       = w_d;
    assign bus.incr_pc   = incr_pc;
    assign bus.ir_in     = ir_in;
    assign bus.done      = done;
    assign bus.halted    = halted;
    assign bus.illegal   = illegal;
    assign bus.fpu_err   = fpu_err;

endmodule

// File: tb/tb_ctrl_unit_fsm_p.sv
// tb/tb_ctrl_unit_fsm_p.sv - cycle-table bench for ctrl_unit_fsm_p
module tb_ctrl_unit_fsm_p;
    import ctrl_pkg::*;

    localparam logic [18:0] C_DIN_OUT   = 19'd1 << 18;
    localparam logic [18:0] C_A_IN      = 19'd1 << 17;
    localparam logic [18:0] C_G_IN      = 19'd1 << 16;
    localparam logic [18:0] C_G_OUT     = 19'd1 << 15;
    localparam logic [18:0] C_ADD_SUB   = 19'd1 << 14;
    localparam logic [18:0] C_AF_IN     = 19'd1 << 13;
    localparam logic [18:0] C_GF_IN     = 19'd1 << 12;
    localparam logic [18:0] C_GF_OUT    = 19'd1 << 11;
    localparam logic [18:0] C_FPU_SUB   = 19'd1 << 10;
    localparam logic [18:0] C_FPU_START = 19'd1 << 9;
    localparam logic [18:0] C_ADDR_IN   = 19'd1 << 8;
    localparam logic [18:0] C_DOUT_IN   = 19'd1 << 7;
    localparam logic [18:0] C_W_D       = 19'd1 << 6;
    localparam logic [18:0] C_INCR_PC   = 19'd1 << 5;
    localparam logic [18:0] C_IR_IN     = 19'd1 << 4;
    localparam logic [18:0] C_DONE      = 19'd1 << 3;
    localparam logic [18:0] C_HALTED    = 19'd1 << 2;
    localparam logic [18:0] C_ILLEGAL   = 19'd1 << 1;
    localparam logic [18:0] C_FPU_ERR   = 19'd1 << 0;

    typedef struct {
        logic        rst;
        logic [9:0]  din;
        logic        g_nz;
        logic        fd;
        state_t      st;
        logic [9:0]  ir;
        logic [7:0]  rin;
        logic [7:0]  rout;
        logic [18:0] ctl;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   nrow = 0;
    bit   immediate = 1'b0;
    logic [9:0] cur_ir = '0;
    vec_t tbl[$];

    ctrl_unit_fsm_p_if #(.NUM_REGS(8)) bus ();

    ctrl_unit_fsm_p #(
        .NUM_REGS(8),
        .MEM_LAT (2),
        .FPU_TMO (15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] ctl_now();
        return {bus.din_out, bus.a_in, bus.g_in, bus.g_out, bus.add_sub,
                bus.af_in, bus.gf_in, bus.gf_out, bus.fpu_sub, bus.fpu_start,
                bus.addr_in, bus.dout_in, bus.w_d, bus.incr_pc,
                bus.ir_in, bus.done, bus.halted, bus.illegal, bus.fpu_err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row%0d got=%h exp=%h", nm, nrow, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        rst          = v.rst;
        bus.din      = v.din;
        bus.g_nz     = v.g_nz;
        bus.fpu_done = v.fd;
        @(posedge clk);
        #1;
        chk("state",   32'(bus.state),   32'(v.st));
        chk("ir",      32'(bus.ir),      32'(v.ir));
        chk("reg_in",  32'(bus.reg_in),  32'(v.rin));
        chk("reg_out", 32'(bus.reg_out), 32'(v.rout));
        chk("ctl",     32'(ctl_now()),   32'(v.ctl));
        nrow++;
    endtask

    task automatic add(input logic r, input logic [9:0] d, input logic g, input logic f,
                       input state_t s, input logic [7:0] ri, input logic [7:0] ro,
                       input logic [18:0] c);
        vec_t v;
        v.rst = r; v.din = d; v.g_nz = g; v.fd = f;
        v.st = s; v.ir = cur_ir; v.rin = ri; v.rout = ro; v.ctl = c;
        if (immediate) run_vec(v);
        else           tbl.push_back(v);
    endtask

    task automatic fetch(input logic [9:0] d);
        add(1'b0, d, 1'b0, 1'b0, S_LDADDR, 8'h00, 8'h80, C_ADDR_IN);
        add(1'b0, d, 1'b0, 1'b0, S_MWAIT,  8'h00, 8'h00, C_INCR_PC);
        add(1'b0, d, 1'b0, 1'b0, S_MWAIT,  8'h00, 8'h00, '0);
        add(1'b0, d, 1'b0, 1'b0, S_FETCH,  8'h00, 8'h00, C_IR_IN);
        cur_ir = d;
        add(1'b0, d, 1'b0, 1'b0, S_DECODE, 8'h00, 8'h00, '0);
    endtask

    initial begin
        bus.din      = '0;
        bus.g_nz     = 1'b0;
        bus.fpu_done = 1'b0;

        add(1'b1, 10'h000, 1'b0, 1'b0, S_RESET, 8'h00, 8'h00, '0);
        add(1'b1, 10'h000, 1'b0, 1'b0, S_RESET, 8'h00, 8'h00, '0);
        // MV R1,R2
        fetch(10'h00A);
        add(1'b0, 10'h00A, 1'b0, 1'b0, S_MV, 8'h02, 8'h04, C_DONE);
        // SUB R2,R3 then ADD R2,R3
        fetch(10'h0D3);
        add(1'b0, 10'h0D3, 1'b0, 1'b0, S_AL1, 8'h00, 8'h04, C_A_IN);
        add(1'b0, 10'h0D3, 1'b0, 1'b0, S_AL2, 8'h00, 8'h08, C_G_IN | C_ADD_SUB);
        add(1'b0, 10'h0D3, 1'b0, 1'b0, S_AL3, 8'h04, 8'h00, C_G_OUT | C_DONE);
        fetch(10'h093);
        add(1'b0, 10'h093, 1'b0, 1'b0, S_AL1, 8'h00, 8'h04, C_A_IN);
        add(1'b0, 10'h093, 1'b0, 1'b0, S_AL2, 8'h00, 8'h08, C_G_IN);
        add(1'b0, 10'h093, 1'b0, 1'b0, S_AL3, 8'h04, 8'h00, C_G_OUT | C_DONE);
        // MVI R1
        fetch(10'h048);
        add(1'b0, 10'h048, 1'b0, 1'b0, S_MVI_A, 8'h00, 8'h80, C_ADDR_IN);
        add(1'b0, 10'h048, 1'b0, 1'b0, S_MVI_W, 8'h00, 8'h00, '0);
        add(1'b0, 10'h048, 1'b0, 1'b0, S_MVI_W, 8'h00, 8'h00, '0);
        add(1'b0, 10'h048, 1'b0, 1'b0, S_MVI_D, 8'h02, 8'h00, C_DIN_OUT | C_INCR_PC | C_DONE);
        // LD R1,[R2]
        fetch(10'h10A);
        add(1'b0, 10'h10A, 1'b0, 1'b0, S_LD_A, 8'h00, 8'h04, C_ADDR_IN);
        add(1'b0, 10'h10A, 1'b0, 1'b0, S_LD_W, 8'h00, 8'h00, '0);
        add(1'b0, 10'h10A, 1'b0, 1'b0, S_LD_W, 8'h00, 8'h00, '0);
        add(1'b0, 10'h10A, 1'b0, 1'b0, S_LD_D, 8'h02, 8'h00, C_DIN_OUT | C_DONE);
        // ST R1,[R2]
        fetch(10'h14A);
        add(1'b0, 10'h14A, 1'b0, 1'b0, S_ST1, 8'h00, 8'h02, C_DOUT_IN);
        add(1'b0, 10'h14A, 1'b0, 1'b0, S_ST2, 8'h00, 8'h04, C_ADDR_IN);
        add(1'b0, 10'h14A, 1'b0, 1'b0, S_ST3, 8'h00, 8'h00, C_W_D | C_DONE);
        // MVNZ R1,R2 with g_nz low then high
        fetch(10'h18A);
        add(1'b0, 10'h18A, 1'b0, 1'b0, S_NOP, 8'h00, 8'h00, C_DONE);
        fetch(10'h18A);
        add(1'b0, 10'h18A, 1'b1, 1'b0, S_MV, 8'h02, 8'h04, C_DONE);
        // ADDF R3,R4 with fpu_done after four wait cycles
        fetch(10'h1DC);
        add(1'b0, 10'h1DC, 1'b0, 1'b0, S_F1, 8'h00, 8'h08, C_AF_IN);
        add(1'b0, 10'h1DC, 1'b0, 1'b0, S_F2, 8'h00, 8'h10, C_GF_IN | C_FPU_START);
        for (int i = 0; i < 4; i++)
            add(1'b0, 10'h1DC, 1'b0, 1'b0, S_FW, 8'h00, 8'h00, '0);
        add(1'b0, 10'h1DC, 1'b0, 1'b1, S_F3, 8'h08, 8'h00, C_GF_OUT | C_DONE);
        // ADDF R1,R2 with fpu_done already in the start cycle
        fetch(10'h1CA);
        add(1'b0, 10'h1CA, 1'b0, 1'b0, S_F1, 8'h00, 8'h02, C_AF_IN);
        add(1'b0, 10'h1CA, 1'b0, 1'b0, S_F2, 8'h00, 8'h04, C_GF_IN | C_FPU_START);
        add(1'b0, 10'h1CA, 1'b0, 1'b1, S_F3, 8'h02, 8'h00, C_GF_OUT | C_DONE);
        // illegal opcode 15
        fetch(10'h3C0);
        add(1'b0, 10'h3C0, 1'b0, 1'b0, S_ILL, 8'h00, 8'h00, C_ILLEGAL | C_DONE);

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        immediate = 1'b1;

        // SUBF R3,R4 never answered: timeout after 15 wait cycles
        fetch(10'h21C);
        add(1'b0, 10'h21C, 1'b0, 1'b0, S_F1, 8'h00, 8'h08, C_AF_IN);
        add(1'b0, 10'h21C, 1'b0, 1'b0, S_F2, 8'h00, 8'h10, C_GF_IN | C_FPU_START | C_FPU_SUB);
        for (int i = 0; i < 15; i++)
            add(1'b0, 10'h21C, 1'b0, 1'b0, S_FW, 8'h00, 8'h00, C_FPU_SUB);
        add(1'b0, 10'h21C, 1'b0, 1'b0, S_FERR, 8'h00, 8'h00, C_FPU_ERR | C_DONE);

        // reset in the middle of an FPU wait; a late fpu_done must not write
        fetch(10'h1DC);
        add(1'b0, 10'h1DC, 1'b0, 1'b0, S_F1, 8'h00, 8'h08, C_AF_IN);
        add(1'b0, 10'h1DC, 1'b0, 1'b0, S_F2, 8'h00, 8'h10, C_GF_IN | C_FPU_START);
        for (int i = 0; i < 3; i++)
            add(1'b0, 10'h1DC, 1'b0, 1'b0, S_FW, 8'h00, 8'h00, '0);
        cur_ir = '0;
        add(1'b1, 10'h1DC, 1'b0, 1'b0, S_RESET, 8'h00, 8'h00, '0);
        add(1'b1, 10'h1DC, 1'b0, 1'b1, S_RESET, 8'h00, 8'h00, '0);

        // HALT holds until reset
        fetch(10'h240);
        for (int i = 0; i < 21; i++)
            add(1'b0, 10'h240, 1'b0, 1'b0, S_HALT, 8'h00, 8'h00, C_HALTED);
        cur_ir = '0;
        add(1'b1, 10'h240, 1'b0, 1'b0, S_RESET, 8'h00, 8'h00, '0);
        add(1'b0, 10'h240, 1'b0, 1'b0, S_LDADDR, 8'h00, 8'h80, C_ADDR_IN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
